// File: rtl/cim_eeg_epoch_sequencer_pkg.sv
// Shared types and constants for the CIM EEG epoch sequencer.
// Holds the FSM state encoding, sample typedefs and the default epoch length.
`timescale 1ns/1ps
`default_nettype none

package cim_eeg_epoch_sequencer_pkg;

    localparam int ADC_W_DEF             = 16;
    localparam int EEG_SAMPLES_PER_EPOCH = 3000;

    typedef logic signed [ADC_W_DEF-1:0] AdcData_t;
    typedef logic [$clog2(EEG_SAMPLES_PER_EPOCH+1)-1:0] SeqCnt_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EPOCH    = 3'd1,
        LOAD     = 3'd2,
        STREAM   = 3'd3,
        WAIT_INF = 3'd4,
        DONE     = 3'd5
    } SeqState_t;

endpackage

`default_nettype wire

// File: rtl/cim_eeg_epoch_sequencer_fifo.sv
// cim_sample_fifo: synchronous FIFO whose head is always a flop output,
// with occupancy, full/empty status and a single-cycle flush.
`timescale 1ns/1ps
`default_nettype none

module cim_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wr_data_i,
    output logic [W-1:0]             rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   occ_o
);

    localparam int AW = $clog2(DEPTH);

    if ((1 << AW) != DEPTH || DEPTH < 2) begin : g_depth_chk
        $error("cim_sample_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   occ_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o   = (occ_q == '0);
    assign full_o    = (occ_q == (AW+1)'(DEPTH));
    assign occ_o     = occ_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when a read frees a slot the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + (AW+1)'(1);
                2'b01:   occ_q <= occ_q - (AW+1)'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/cim_eeg_epoch_sequencer.sv
// cim_eeg_epoch_sequencer: buffers ADC samples and streams one epoch into the CIM.
// Optional channel averaging is enabled by defining EEG_CH_AVG_EN.
`timescale 1ns/1ps
`default_nettype none

module cim_eeg_epoch_sequencer
    import cim_eeg_epoch_sequencer_pkg::*;
#(
    parameter int NUM_CH            = 4,
    parameter int ADC_W             = ADC_W_DEF,
    parameter int FIFO_DEPTH        = 8,
    parameter int SAMPLES_PER_EPOCH = EEG_SAMPLES_PER_EPOCH,
    parameter int GAP_CYCLES        = 2,
    parameter int TIMEOUT_CYCLES    = 2**20
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        adc_valid_i,
    input  logic [NUM_CH*ADC_W-1:0]                     adc_data_i,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch_sel_i,
    input  logic                                        cfg_avg_i,
    input  logic                                        host_start_i,
    input  logic                                        host_abort_i,
    output logic                                        busy_o,
    output logic                                        done_o,
    output logic                                        err_timeout_o,
    output logic                                        err_overflow_o,
    output logic [$clog2(SAMPLES_PER_EPOCH+1)-1:0]      sample_cnt_o,
    output logic                                        cim_new_sleep_epoch_o,
    output logic                                        cim_start_eeg_load_o,
    output logic                                        cim_new_eeg_data_o,
    output logic [ADC_W-1:0]                            cim_eeg_o,
    input  logic                                        cim_inference_complete_i
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(SAMPLES_PER_EPOCH+1);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES+1);
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    SeqState_t         state_q;
    logic [CH_W-1:0]   ch_sel_q;
    logic [CNT_W-1:0]  sample_cnt_q;
    logic [GAP_W-1:0]  gap_q;
    logic [TO_W-1:0]   wait_cnt_q;
    logic              err_timeout_q;
    logic              err_overflow_q;
    logic              new_sleep_epoch_q;
    logic              start_eeg_load_q;
    logic              new_eeg_data_q;
    logic              done_q;
    logic [ADC_W-1:0]  cim_eeg_q;

    logic [ADC_W-1:0]  sel_sample;
    logic [ADC_W-1:0]  push_data;
    logic [ADC_W-1:0]  fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OCC_W-1:0]  fifo_occ;
    logic              in_window;
    logic              has_room;
    logic              accept;
    logic              push;
    logic              pop;
    logic              overflow;
    logic              abort;

    always_comb begin
        sel_sample = adc_data_i[ADC_W-1:0];
        for (int c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == ch_sel_q) sel_sample = adc_data_i[c*ADC_W +: ADC_W];
        end
    end

`ifdef EEG_CH_AVG_EN
    localparam int AVG_SH = $clog2(NUM_CH);
    localparam int SUM_W  = ADC_W + AVG_SH;

    if ((1 << AVG_SH) != NUM_CH) begin : g_avg_pow2_chk
        $error("cim_eeg_epoch_sequencer: NUM_CH must be a power of 2 when averaging");
    end

    logic                    cfg_avg_q;
    logic signed [SUM_W-1:0] ch_sum;
    logic signed [SUM_W-1:0] ch_avg;

    always_comb begin
        ch_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_sum = ch_sum + SUM_W'(signed'(adc_data_i[c*ADC_W +: ADC_W]));
        end
    end

    assign ch_avg    = ch_sum >>> AVG_SH;
    assign push_data = cfg_avg_q ? ch_avg[ADC_W-1:0] : sel_sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               cfg_avg_q <= 1'b0;
        else if (state_q == IDLE && host_start_i) cfg_avg_q <= cfg_avg_i;
    end
`else
    logic unused_cfg_avg;
    assign unused_cfg_avg = cfg_avg_i;
    assign push_data      = sel_sample;
`endif

    assign abort     = host_abort_i && (state_q != IDLE);
    assign in_window = (state_q == LOAD) || (state_q == STREAM);
    // Never buffer more than the epoch still needs, so leftovers cannot leak into the next one.
    assign has_room  = (int'(sample_cnt_q) + int'(fifo_occ)) < SAMPLES_PER_EPOCH;
    assign accept    = adc_valid_i && in_window && has_room && !abort;
    assign pop       = (state_q == STREAM) && !fifo_empty && (gap_q == '0) && !abort;
    assign push      = accept && (!fifo_full || pop);
    assign overflow  = accept && fifo_full && !pop;

    cim_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ADC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (abort),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (push_data),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .occ_o     (fifo_occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            ch_sel_q          <= '0;
            sample_cnt_q      <= '0;
            gap_q             <= '0;
            wait_cnt_q        <= '0;
            err_timeout_q     <= 1'b0;
            err_overflow_q    <= 1'b0;
            new_sleep_epoch_q <= 1'b0;
            start_eeg_load_q  <= 1'b0;
            new_eeg_data_q    <= 1'b0;
            done_q            <= 1'b0;
            cim_eeg_q         <= '0;
        end else begin
            new_sleep_epoch_q <= 1'b0;
            start_eeg_load_q  <= 1'b0;
            new_eeg_data_q    <= 1'b0;
            done_q            <= 1'b0;

            if (overflow) err_overflow_q <= 1'b1;

            if (pop) begin
                new_eeg_data_q <= 1'b1;
                cim_eeg_q      <= fifo_head;
                sample_cnt_q   <= sample_cnt_q + CNT_W'(1);
                gap_q          <= GAP_W'(GAP_CYCLES);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
            end

            if (abort) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (host_start_i) begin
                            state_q           <= EPOCH;
                            new_sleep_epoch_q <= 1'b1;
                            err_timeout_q     <= 1'b0;
                            err_overflow_q    <= 1'b0;
                            sample_cnt_q      <= '0;
                            gap_q             <= '0;
                            ch_sel_q          <= cfg_ch_sel_i;
                        end
                    end
                    EPOCH: begin
                        state_q          <= LOAD;
                        start_eeg_load_q <= 1'b1;
                    end
                    LOAD: state_q <= STREAM;
                    STREAM: begin
                        if (pop && sample_cnt_q == CNT_W'(SAMPLES_PER_EPOCH-1)) begin
                            state_q    <= WAIT_INF;
                            wait_cnt_q <= '0;
                        end
                    end
                    WAIT_INF: begin
                        if (cim_inference_complete_i) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES-1)) begin
                            state_q       <= IDLE;
                            err_timeout_q <= 1'b1;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + TO_W'(1);
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy_o                = (state_q != IDLE);
    assign done_o                = done_q;
    assign err_timeout_o         = err_timeout_q;
    assign err_overflow_o        = err_overflow_q;
    assign sample_cnt_o          = sample_cnt_q;
    assign cim_new_sleep_epoch_o = new_sleep_epoch_q;
    assign cim_start_eeg_load_o  = start_eeg_load_q;
    assign cim_new_eeg_data_o    = new_eeg_data_q;
    assign cim_eeg_o             = cim_eeg_q;

endmodule

`default_nettype wire

// File: tb/tb_cim_eeg_epoch_sequencer.sv
// Directed testbench for cim_eeg_epoch_sequencer: nominal epoch, overflow,
// timeout, abort/restart, channel average and asynchronous reset.
`timescale 1ns/1ps
`default_nettype none

module tb_cim_eeg_epoch_sequencer;

    localparam int NUM_CH = 4;
    localparam int ADC_W  = 16;
    localparam int SPE    = 3000;
    localparam int TMO    = 100;
    localparam int CNT_W  = $clog2(SPE+1);
    localparam logic [15:0] C0 = 16'h0AAA, C1 = 16'h0BBB, C3 = 16'h0DDD;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    adc_valid = 1'b0;
    logic [NUM_CH*ADC_W-1:0] adc_data = '0;
    logic [1:0]              cfg_ch_sel = 2'd2;
    logic                    cfg_avg = 1'b0;
    logic                    host_start = 1'b0;
    logic                    host_abort = 1'b0;
    logic                    inf_done = 1'b0;
    logic                    busy, done, err_timeout, err_overflow;
    logic [CNT_W-1:0]        sample_cnt;
    logic                    new_epoch, start_load, new_data;
    logic [ADC_W-1:0]        cim_eeg;

    int errors = 0;
    int checks = 0;

    int          cyc = 0;
    int          pulse_cnt = 0;
    int          last_pulse_cyc = 0;
    int          min_gap = 0;
    int          to_rise_cyc = -1;
    int          done_cnt = 0;
    logic        prev_to = 1'b0;
    logic [15:0] got_q[$];
    bit          drv_stop = 1'b0;

    cim_eeg_epoch_sequencer #(
        .NUM_CH            (NUM_CH),
        .ADC_W             (ADC_W),
        .FIFO_DEPTH        (8),
        .SAMPLES_PER_EPOCH (SPE),
        .GAP_CYCLES        (2),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .adc_valid_i              (adc_valid),
        .adc_data_i               (adc_data),
        .cfg_ch_sel_i             (cfg_ch_sel),
        .cfg_avg_i                (cfg_avg),
        .host_start_i             (host_start),
        .host_abort_i             (host_abort),
        .busy_o                   (busy),
        .done_o                   (done),
        .err_timeout_o            (err_timeout),
        .err_overflow_o           (err_overflow),
        .sample_cnt_o             (sample_cnt),
        .cim_new_sleep_epoch_o    (new_epoch),
        .cim_start_eeg_load_o     (start_load),
        .cim_new_eeg_data_o       (new_data),
        .cim_eeg_o                (cim_eeg),
        .cim_inference_complete_i (inf_done)
    );

    always #5 clk = ~clk;

    // Passive recorder: pulse values, spacing, done pulses and timeout edge.
    always @(negedge clk) begin
        cyc++;
        if (new_data === 1'b1) begin
            if (pulse_cnt > 0 && (cyc - last_pulse_cyc) < min_gap) min_gap = cyc - last_pulse_cyc;
            last_pulse_cyc = cyc;
            pulse_cnt++;
            got_q.push_back(cim_eeg);
        end
        if (done === 1'b1) done_cnt++;
        if (err_timeout === 1'b1 && prev_to !== 1'b1) to_rise_cyc = cyc;
        prev_to = err_timeout;
    end

    task automatic clear_mon();
        got_q.delete();
        pulse_cnt   = 0;
        min_gap     = 1 << 30;
        to_rise_cyc = -1;
        done_cnt    = 0;
        drv_stop    = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) host_start = 1'b1;
        @(negedge clk) host_start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk) host_abort = 1'b1;
        @(negedge clk) host_abort = 1'b0;
    endtask

    task automatic drive_ramp(input int period, input int base, input int n);
        for (int k = 0; k < n && !drv_stop; k++) begin
            adc_data  = {C3, 16'(base + k), C1, C0};
            adc_valid = 1'b1;
            @(negedge clk);
            adc_valid = 1'b0;
            repeat (period - 1) @(negedge clk);
        end
        adc_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (pulse_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, err_timeout, err_overflow, new_epoch, start_load, new_data} !== 7'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000000", {busy, done, err_timeout, err_overflow, new_epoch, start_load, new_data}); end
        checks++; if (sample_cnt !== '0) begin errors++; $display("FAIL reset_sample_cnt: got %0d expected 0", sample_cnt); end
        checks++; if (cim_eeg !== '0) begin errors++; $display("FAIL reset_cim_eeg: got %0d expected 0", cim_eeg); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b expected 0", busy); end
    endtask

    task automatic test_nominal();
        bit ok1, ok2;
        int nbad;
        clear_mon();
        cfg_ch_sel = 2'd2;
        pulse_start();
        checks++; if ({new_epoch, busy, start_load} !== 3'b110) begin errors++; $display("FAIL epoch_pulse: got %b expected 110", {new_epoch, busy, start_load}); end
        checks++; if (sample_cnt !== '0) begin errors++; $display("FAIL start_cnt: got %0d expected 0", sample_cnt); end
        @(negedge clk);
        checks++; if ({new_epoch, start_load} !== 2'b01) begin errors++; $display("FAIL load_pulse: got %b expected 01", {new_epoch, start_load}); end
        fork
            drive_ramp(3, 0, SPE + 3);
            begin
                wait_pulses(100, 1000, ok1);
                pulse_start();
                wait_pulses(SPE, 12000, ok2);
                drv_stop = 1'b1;
            end
        join
        @(negedge clk);
        checks++; if ((ok1 && ok2) !== 1'b1) begin errors++; $display("FAIL nominal_budget: got %b expected 1", ok1 && ok2); end
        checks++; if (pulse_cnt !== SPE) begin errors++; $display("FAIL nominal_pulses: got %0d expected %0d", pulse_cnt, SPE); end
        nbad = 0;
        foreach (got_q[i]) if (got_q[i] !== 16'(i)) nbad++;
        checks++; if (nbad !== 0) begin errors++; $display("FAIL nominal_values: got %0d wrong values expected 0", nbad); end
        checks++; if (min_gap !== 3) begin errors++; $display("FAIL nominal_gap: got %0d expected 3", min_gap); end
        checks++; if (sample_cnt !== CNT_W'(SPE)) begin errors++; $display("FAIL nominal_cnt: got %0d expected %0d", sample_cnt, SPE); end
        checks++; if ({busy, done, err_overflow} !== 3'b100) begin errors++; $display("FAIL wait_inf_state: got %b expected 100", {busy, done, err_overflow}); end
        @(negedge clk) inf_done = 1'b1;
        @(negedge clk) inf_done = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b expected 1", done); end
        @(negedge clk);
        checks++; if ({done, busy, done_cnt[1:0]} !== 4'b0001) begin errors++; $display("FAIL done_end: got %b expected 0001", {done, busy, done_cnt[1:0]}); end
    endtask

    task automatic test_overflow_timeout();
        bit ok;
        int nbad;
        clear_mon();
        pulse_start();
        @(negedge clk);
        fork
            drive_ramp(1, 0, 20000);
            begin
                wait_pulses(SPE, 12000, ok);
                drv_stop = 1'b1;
            end
        join
        @(negedge clk);
        checks++; if (ok !== 1'b1 || pulse_cnt !== SPE) begin errors++; $display("FAIL ovf_pulses: got %0d expected %0d", pulse_cnt, SPE); end
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", err_overflow); end
        checks++; if (min_gap !== 3) begin errors++; $display("FAIL ovf_gap: got %0d expected 3", min_gap); end
        nbad = 0;
        for (int i = 0; i < 8 && i < got_q.size(); i++) if (got_q[i] !== 16'(i)) nbad++;
        for (int i = 1; i < got_q.size(); i++) if (got_q[i] <= got_q[i-1]) nbad++;
        checks++; if (nbad !== 0) begin errors++; $display("FAIL ovf_values: got %0d bad values expected 0", nbad); end
        for (int k = 0; k < 300 && to_rise_cyc < 0; k++) @(posedge clk);
        @(negedge clk);
        checks++; if (to_rise_cyc - last_pulse_cyc !== TMO) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d", to_rise_cyc - last_pulse_cyc, TMO); end
        repeat (5) @(negedge clk);
        checks++; if ({err_timeout, err_overflow, busy} !== 3'b110) begin errors++; $display("FAIL timeout_state: got %b expected 110", {err_timeout, err_overflow, busy}); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL timeout_no_done: got %0d expected 0", done_cnt); end
    endtask

    task automatic test_abort();
        bit ok;
        int n0;
        clear_mon();
        pulse_start();
        checks++; if ({err_timeout, err_overflow} !== 2'b00) begin errors++; $display("FAIL start_clears_err: got %b expected 00", {err_timeout, err_overflow}); end
        @(negedge clk);
        fork
            drive_ramp(1, 0, 5000);
            begin
                wait_pulses(500, 3000, ok);
                @(negedge clk);
                host_abort = 1'b1;
                drv_stop   = 1'b1;
                @(negedge clk);
                host_abort = 1'b0;
                checks++; if ((ok && !busy) !== 1'b1) begin errors++; $display("FAIL abort_idle: busy got %b expected 0", busy); end
                n0 = pulse_cnt;
                repeat (10) @(negedge clk);
                checks++; if (pulse_cnt !== n0) begin errors++; $display("FAIL abort_quiet: got %0d pulses expected %0d", pulse_cnt, n0); end
            end
        join
        clear_mon();
        pulse_start();
        checks++; if (sample_cnt !== '0) begin errors++; $display("FAIL restart_cnt: got %0d expected 0", sample_cnt); end
        @(negedge clk);
        fork
            drive_ramp(3, 5000, 5);
            wait_pulses(5, 200, ok);
        join
        repeat (3) @(negedge clk);
        checks++; if (pulse_cnt !== 5 || got_q.size() < 1 || got_q[0] !== 16'd5000) begin errors++; $display("FAIL restart_flushed: got %0d pulses first %0d expected 5 pulses first 5000", pulse_cnt, (got_q.size() > 0) ? int'(got_q[0]) : -1); end
        checks++; if (sample_cnt !== CNT_W'(5)) begin errors++; $display("FAIL restart_sample_cnt: got %0d expected 5", sample_cnt); end
        pulse_abort();
    endtask

    task automatic test_avg();
        bit ok;
        logic [15:0] expv;
`ifdef EEG_CH_AVG_EN
        expv = 16'd74;
`else
        expv = 16'd300;
`endif
        clear_mon();
        cfg_avg = 1'b1;
        pulse_start();
        @(negedge clk);
        adc_data  = {16'hFFFC, 16'd300, 16'hFF9C, 16'd100};
        adc_valid = 1'b1;
        @(negedge clk) adc_valid = 1'b0;
        wait_pulses(1, 50, ok);
        @(negedge clk);
        checks++; if (ok !== 1'b1 || cim_eeg !== expv) begin errors++; $display("FAIL avg_value: got %0d expected %0d", cim_eeg, expv); end
        cfg_avg = 1'b0;
        pulse_abort();
    endtask

    task automatic test_async_reset();
        bit ok;
        clear_mon();
        pulse_start();
        @(negedge clk);
        fork
            drive_ramp(3, 0, 100);
            begin
                wait_pulses(20, 200, ok);
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                checks++; if ((ok && !busy) !== 1'b1) begin errors++; $display("FAIL async_busy: got %b expected 0", busy); end
                checks++; if (sample_cnt !== '0 || cim_eeg !== '0) begin errors++; $display("FAIL async_regs: cnt %0d eeg %0d expected 0 0", sample_cnt, cim_eeg); end
                checks++; if ({done, err_timeout, err_overflow, new_epoch, start_load, new_data} !== 6'b0) begin errors++; $display("FAIL async_flags: got %b expected 000000", {done, err_timeout, err_overflow, new_epoch, start_load, new_data}); end
                drv_stop = 1'b1;
                @(negedge clk) rst_n = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_release_idle: busy got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overflow_timeout();
        test_abort();
        test_avg();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
